// File: rtl/axi4stream_output_serializer.sv
// -----------------------------------------------------------------------------
// axi4stream_output_serializer
//
// Takes one BUFFER_WIDTH-bit word through a valid/ready handshake and sends it
// out as ceil(BUFFER_WIDTH/AXI_WIDTH) AXI4-Stream beats, least-significant
// slice first. tlast marks the final beat of each word. If the final beat is
// only partly filled, its upper bits are zero. A new word can be accepted on
// the last-beat handshake, so consecutive words stream without a bubble.
//
// Optional feature macro: AXI4S_SERIALIZER_TKEEP_EN
//   When defined, a tkeep output is added (AXI_WIDTH must be a multiple of 8).
//   It is all-ones on every beat except the final one, where only the bytes
//   that carry real buffer bits are set.
//
// Ports:
//   aclk       in   clock, rising edge
//   areset     in   asynchronous reset, active low
//   buf_data   in   [BUFFER_WIDTH] word to transmit
//   buf_valid  in   buf_data is valid
//   buf_ready  out  word is accepted this cycle (buf_valid && buf_ready)
//   tdata      out  [AXI_WIDTH] stream data
//   tvalid     out  stream beat valid
//   tlast      out  final beat of the word
//   tkeep      out  [AXI_WIDTH/8] byte qualifiers (macro builds only)
//   tready     in   downstream ready
//   busy       out  a word is latched and not yet fully sent
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module axi4stream_output_serializer #(
    parameter int AXI_WIDTH    = 8,
    parameter int BUFFER_WIDTH = 64
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [BUFFER_WIDTH-1:0] buf_data,
    input  logic                    buf_valid,
    output logic                    buf_ready,
    output logic [AXI_WIDTH-1:0]    tdata,
    output logic                    tvalid,
    output logic                    tlast,
`ifdef AXI4S_SERIALIZER_TKEEP_EN
    output logic [AXI_WIDTH/8-1:0]  tkeep,
`endif
    input  logic                    tready,
    output logic                    busy
);

    localparam int BEATS   = (BUFFER_WIDTH + AXI_WIDTH - 1) / AXI_WIDTH;
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    // The shift register is padded up to a whole number of beats so the
    // final slice reads zeros above the real data.
    localparam int SHIFT_W = BEATS * AXI_WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

`ifdef AXI4S_SERIALIZER_TKEEP_EN
    localparam int KEEP_W     = AXI_WIDTH / 8;
    localparam int LAST_BITS  = BUFFER_WIDTH - (BEATS - 1) * AXI_WIDTH;
    localparam int LAST_BYTES = (LAST_BITS + 7) / 8;
    localparam logic [KEEP_W-1:0] KEEP_LAST = {KEEP_W{1'b1}} >> (KEEP_W - LAST_BYTES);
`endif

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic                last_beat;

    assign last_beat = (state_q == SEND) && (cnt_q == LAST_CNT);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;

        // Outputs depend only on registered state; tvalid never looks at tready,
        // so everything holds steady under backpressure.
        tvalid    = (state_q == SEND);
        tlast     = last_beat;
        tdata     = tvalid ? shift_q[AXI_WIDTH-1:0] : '0;
        busy      = tvalid;
        // In SEND a new word is only taken on the last-beat handshake.
        buf_ready = (state_q == IDLE) || (last_beat && tready);
`ifdef AXI4S_SERIALIZER_TKEEP_EN
        tkeep     = !tvalid ? '0 : (last_beat ? KEEP_LAST : '1);
`endif

        case (state_q)
            IDLE: begin
                if (buf_valid) begin
                    shift_d = SHIFT_W'(buf_data);
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tready) begin
                    if (!last_beat) begin
                        shift_d = shift_q >> AXI_WIDTH;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else if (buf_valid) begin
                        shift_d = SHIFT_W'(buf_data);
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make all registers update together
            // from the same pre-edge values, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: tb/tb_axi4stream_output_serializer.sv
`timescale 1ns/1ps

module tb_axi4stream_output_serializer;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    int checks = 0;
    int errors = 0;

    // Default-parameter instance (AXI_WIDTH=8, BUFFER_WIDTH=64)
    logic        aclk = 1'b0;
    logic        areset;
    logic [63:0] buf_data;
    logic        buf_valid;
    logic        buf_ready;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic        busy;
`ifdef AXI4S_SERIALIZER_TKEEP_EN
    logic [0:0]  tkeep;
`endif

    // Non-multiple instance (AXI_WIDTH=8, BUFFER_WIDTH=36)
    logic [35:0] d36_data;
    logic        d36_valid;
    logic        d36_ready;
    logic [7:0]  d36_tdata;
    logic        d36_tvalid;
    logic        d36_tlast;
    logic        d36_tready;
    logic        d36_busy;
`ifdef AXI4S_SERIALIZER_TKEEP_EN
    logic [0:0]  d36_tkeep;
`endif

    always #5 aclk = ~aclk;

    axi4stream_output_serializer #(.AXI_WIDTH(8), .BUFFER_WIDTH(64)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .buf_data  (buf_data),
        .buf_valid (buf_valid),
        .buf_ready (buf_ready),
        .tdata     (tdata),
        .tvalid    (tvalid),
        .tlast     (tlast),
`ifdef AXI4S_SERIALIZER_TKEEP_EN
        .tkeep     (tkeep),
`endif
        .tready    (tready),
        .busy      (busy)
    );

    axi4stream_output_serializer #(.AXI_WIDTH(8), .BUFFER_WIDTH(36)) dut36 (
        .aclk      (aclk),
        .areset    (areset),
        .buf_data  (d36_data),
        .buf_valid (d36_valid),
        .buf_ready (d36_ready),
        .tdata     (d36_tdata),
        .tvalid    (d36_tvalid),
        .tlast     (d36_tlast),
`ifdef AXI4S_SERIALIZER_TKEEP_EN
        .tkeep     (d36_tkeep),
`endif
        .tready    (d36_tready),
        .busy      (d36_busy)
    );

    beat_t q[$];
    beat_t q36[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected beats of one word: byte i of the zero-extended word, last on beat n-1.
    task automatic push_word(input logic [63:0] word, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = 8'(word >> (8 * i));
            b.last = (i == n - 1);
            q.push_back(b);
        end
    endtask

    // Monitor: compares every handshaken beat with the scoreboard head and
    // checks that a stalled beat is presented unchanged on the next cycle.
    logic       hold_pending = 1'b0;
    logic [7:0] held_data;
    logic       held_last;

    always @(negedge aclk) begin
        beat_t e;
        if (areset) begin
            if (hold_pending) begin
                check("hold_tvalid", 64'(tvalid), 64'd1);
                check("hold_tdata", 64'(tdata), 64'(held_data));
                check("hold_tlast", 64'(tlast), 64'(held_last));
            end
            hold_pending = tvalid && !tready;
            held_data    = tdata;
            held_last    = tlast;
            if (tvalid && tready) begin
                check("beat_expected", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("beat_tdata", 64'(tdata), 64'(e.data));
                    check("beat_tlast", 64'(tlast), 64'(e.last));
`ifdef AXI4S_SERIALIZER_TKEEP_EN
                    check("beat_tkeep", 64'(tkeep), 64'd1);
`endif
                end
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    // Raise buf_valid with a word and wait (bounded) for the accept.
    task automatic send_word(input logic [63:0] word);
        logic done = 1'b0;
        @(posedge aclk); #1;
        buf_valid = 1'b1;
        buf_data  = word;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge aclk);
            if (buf_ready) begin
                push_word(word, 8);
                @(posedge aclk); #1;
                buf_valid = 1'b0;
                done = 1'b1;
            end
        end
        check("accept_timeout", 64'(done), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge aclk);
        check("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t e;
        areset     = 1'b0;
        buf_data   = '0;
        buf_valid  = 1'b0;
        tready     = 1'b1;
        d36_data   = '0;
        d36_valid  = 1'b0;
        d36_tready = 1'b1;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_tdata", 64'(tdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_buf_ready", 64'(buf_ready), 64'd1);
        #2 areset = 1'b1;
        @(negedge aclk);
        check("post_rst_tvalid", 64'(tvalid), 64'd0);

        // Single word at full rate; buf_ready low on beats 1-7, high on beat 8
        send_word(64'h87654321DEADBEEF);
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            check("t1_tvalid", 64'(tvalid), 64'd1);
            check("t1_buf_ready", 64'(buf_ready), 64'(i == 7));
        end
        drain();

        // Backpressure: tready 1,0,0,1,0,0,...
        send_word(64'h87654321DEADBEEF);
        for (int i = 0; i < 30; i++) begin
            tready = (i % 3 == 0);
            @(posedge aclk); #1;
        end
        tready = 1'b1;
        drain();

        // Back-to-back words with buf_valid held
        @(posedge aclk); #1;
        buf_valid = 1'b1;
        buf_data  = 64'h1111111111111111;
        @(negedge aclk);
        check("b2b_first_ready", 64'(buf_ready), 64'd1);
        push_word(64'h1111111111111111, 8);
        @(posedge aclk); #1;
        buf_data = 64'h2222222222222222;
        for (int k = 0; k < 16; k++) begin
            @(negedge aclk);
            check("b2b_tvalid", 64'(tvalid), 64'd1);
            if (k == 7) begin
                check("b2b_ready_last", 64'(buf_ready), 64'd1);
                push_word(64'h2222222222222222, 8);
                @(posedge aclk); #1;
                buf_valid = 1'b0;
            end else if (k != 15) begin
                check("b2b_ready_low", 64'(buf_ready), 64'd0);
            end
        end
        @(negedge aclk);
        check("b2b_idle_after", 64'(tvalid), 64'd0);
        drain();

        // Asynchronous reset after three beats
        send_word(64'h1122334455667788);
        repeat (3) @(negedge aclk);
        @(posedge aclk); #2;
        areset = 1'b0;
        #1;
        check("mid_rst_tvalid", 64'(tvalid), 64'd0);
        check("mid_rst_tlast", 64'(tlast), 64'd0);
        check("mid_rst_tdata", 64'(tdata), 64'd0);
        check("mid_rst_buf_ready", 64'(buf_ready), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        q.delete();
        @(negedge aclk);
        @(posedge aclk); #2;
        areset = 1'b1;
        @(negedge aclk);
        check("mid_rst_no_beat", 64'(tvalid), 64'd0);
        send_word(64'h0102030405060708);
        drain();

        // Idle for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            check("idle_tvalid", 64'(tvalid), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_buf_ready", 64'(buf_ready), 64'd1);
        end

        // 36-bit word on 8-bit stream: 12,F0,DE,BC,0A
        @(posedge aclk); #1;
        d36_valid = 1'b1;
        d36_data  = 36'hABCDEF012;
        @(negedge aclk);
        check("d36_ready", 64'(d36_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            e.data = 8'(64'h0000000ABCDEF012 >> (8 * i));
            e.last = (i == 4);
            q36.push_back(e);
        end
        @(posedge aclk); #1;
        d36_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            e = q36.pop_front();
            check("d36_tvalid", 64'(d36_tvalid), 64'd1);
            check("d36_tdata", 64'(d36_tdata), 64'(e.data));
            check("d36_tlast", 64'(d36_tlast), 64'(e.last));
`ifdef AXI4S_SERIALIZER_TKEEP_EN
            check("d36_tkeep", 64'(d36_tkeep), 64'd1);
`endif
        end
        @(negedge aclk);
        check("d36_idle", 64'(d36_tvalid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4stream_output_serializer.md
Name: axi4stream_output_serializer

Overview:
- Downstream counterpart of axi4stream_input_buffer.
- Takes one wide parallel word through a valid/ready handshake and serializes it onto an AXI4-Stream master as ceil(BUFFER_WIDTH/AXI_WIDTH) beats, least-significant slice first.
- Asserts tlast on the final beat.
- Returns processed pixel/line words from the upscaler core to the stream fabric, so a word captured by the input buffer round-trips unchanged.

Parameters:
- AXI_WIDTH, 8, stream data width in bits.
- BUFFER_WIDTH, 64, parallel word width in bits; need not be a multiple of AXI_WIDTH.

Ports:
- aclk  input  1  clock; all logic is rising-edge.
- areset  input  1  asynchronous, active-low reset (0 = reset asserted).
- buf_data  input  BUFFER_WIDTH  word to transmit.
- buf_valid  input  1  buf_data is valid.
- buf_ready  output  1  block accepts buf_data this cycle.
- tdata  output  AXI_WIDTH  stream data.
- tvalid  output  1  stream beat valid.
- tlast  output  1  final beat of the word.
- tready  input  1  downstream consumer ready.
- busy  output  1  a word is latched and not yet fully sent.

Behaviour:
- Constant BEATS = ceil(BUFFER_WIDTH/AXI_WIDTH). Beat counter width = clog2(BEATS), minimum 1 bit.
- Reset (areset low, asynchronous):
  - tvalid=0, tlast=0, tdata=0, busy=0, buf_ready=1, counter=0, state=IDLE.
  - Any partially sent word is discarded.
  - No beat is emitted in the first cycle after release.
- Transfers: input accept = buf_valid&&buf_ready; beat = tvalid&&tready.
- State IDLE:
  - buf_ready=1, tvalid=0.
  - On accept: latch buf_data into shift register, counter=0, go to SEND.
  - Latency: first beat appears on tvalid the cycle after accept.
- State SEND:
  - tvalid=1, tdata = shift_reg[AXI_WIDTH-1:0], tlast = (counter==BEATS-1).
  - On beat, not last: shift right by AXI_WIDTH, counter+1.
  - On beat, last: if buf_valid also high, accept the new word that same cycle (buf_ready=1 only in this case within SEND), reload, counter=0, stay in SEND. This gives back-to-back words with no bubble. Otherwise go to IDLE.
  - Outside the last-beat handshake, buf_ready=0 in SEND.
- AXI stability: while tvalid=1 and tready=0, tdata/tlast/tvalid hold unchanged. tvalid never depends combinationally on tready.
- Padding: if BUFFER_WIDTH is not a multiple of AXI_WIDTH, the upper bits of the final beat are 0.
- BEATS=1: every beat has tlast=1.
- busy = (state==SEND).
- Counter never wraps past BEATS-1.
- buf_data changes while in SEND are ignored.

Optional Feature:
- Macro: AXI4S_SERIALIZER_TKEEP_EN.
- When defined:
  - Extra output tkeep, width AXI_WIDTH/8; AXI_WIDTH must be a multiple of 8.
  - All-ones on non-final beats.
  - On the final beat, only bytes containing real buffer bits are set. Example: BUFFER_WIDTH=36, AXI_WIDTH=16 gives final tkeep=2'b01.
  - Reset value 0; held stable under backpressure like tdata.
- When undefined: no tkeep port and no related logic. Behaviour otherwise identical.

Test Plan:
- Default params, buf_data=64'h87654321DEADBEEF, tready=1 -> tdata sequence EF,BE,AD,DE,21,43,65,87 on 8 consecutive cycles; tlast only on 87; buf_ready low during beats 1-7.
- Backpressure: same word, tready toggled 1,0,0,1,... -> each byte held stable while tready=0; exactly 8 beats, order unchanged, tlast once.
- Back-to-back: buf_valid held with 64'h1111..11 then 64'h2222..22 -> 16 contiguous beats (eight 11, eight 22), no idle cycle; tlast on beats 8 and 16.
- BUFFER_WIDTH=36, AXI_WIDTH=8, data 36'hA_BCDE_F012 -> beats 12,F0,DE,BC,0A; tlast on 0A; with macro defined, tkeep=1 on all beats.
- Reset mid-word: areset driven low after 3 beats -> tvalid/tlast/tdata go 0 immediately (asynchronous), buf_ready=1. After release, a new word 64'h0102030405060708 starts at 08 with the counter cleared.
- Idle: buf_valid=0 for 20 cycles -> tvalid=0, busy=0, buf_ready=1 throughout.
